ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the ram64K (64K x 8, synchronous write) memory.
- Port A is the CPU load/store path. Port B is the program loader / DMA path.
- Grants one access at a time, drives the RAM strobes for exactly one issue cycle, and waits out the RAM read latency.
- Returns read data to the winning requester with a one-cycle ack pulse.

Parameters:
- RD_LAT, 1: cycles from the issue edge until ram_rdata is valid (legal 1-4).
- FIXED_PRIO, 0: 0 = round-robin between A and B; 1 = A always wins ties.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A access request; held high until a_ack.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  16  port A byte address.
- a_wdata  in  8  port A write data.
- a_ack  out  1  port A completion pulse, one cycle.
- a_rdata  out  8  port A read data, valid when a_ack=1, held afterwards.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as the port A signals, for port B.
- ram_we  out  1  to ram64K we.
- ram_addr  out  16  to ram64K addr.
- ram_wdata  out  8  to ram64K wdata.
- ram_rdata  in  8  from ram64K rdata.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  current/last grant: 0 = A, 1 = B.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, owner=1, so A wins the first round-robin tie.
  - wait counter=0.
- Reset mid-access: the access is abandoned, no ack is issued, ram_we drops at once. Requesters re-request after reset.
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If neither req is high, stay.
  - If exactly one req is high, grant it.
  - If both are high: with FIXED_PRIO=1 grant A; with FIXED_PRIO=0 grant the port that is not owner.
  - On grant: latch we/addr/wdata of the winner, set owner, go to ISSUE.
- ISSUE (one cycle):
  - ram_addr=latched addr, ram_wdata=latched wdata, ram_we=latched we.
  - Write: go to DONE.
  - Read: load counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - ram_we=0 and ram_addr is held.
  - Decrement the counter each cycle. At 0, capture ram_rdata into the owner's rdata register and go to DONE.
  - With RD_LAT=1, WAIT lasts one cycle.
- DONE (one cycle):
  - Owner's ack=1, ram_we=0, then go to IDLE.
  - The non-owner's rdata is never modified. A write never modifies any rdata.
- Latency, counted from the edge where req is sampled in IDLE:
  - Write: ack at cycle 3 (IDLE→ISSUE→DONE).
  - Read: ack at cycle 3+RD_LAT.
  - Back-to-back throughput: one write per 3 cycles; one read per 3+RD_LAT cycles.
- Handshake:
  - req must stay high until ack, and command inputs must stay stable until the grant edge. Changes after the grant are ignored because the command is latched.
  - A req still high in the cycle after ack is a new request.
  - req dropped before grant means no access is performed.
- Round-robin: if both ports hold req continuously, grants alternate A, B, A, … with no starvation. Under FIXED_PRIO=1, port B can starve; this is accepted.
- Writing to a request input while that port is not owner has no effect on the current access.
- Address covers the full 0x0000–0xFFFF range; no wrap logic, and 0xFFFF is a legal address.
- ram_we is high for exactly one cycle per write access and never during reads.

Test Plan:
1. Reset then A write: a_req=1, a_we=1, a_addr=0x1234, a_wdata=0xAB → ram_we high for exactly one cycle with addr 0x1234 and data 0xAB; a_ack pulses 3 cycles after the request is sampled; busy high for 2 cycles.
2. A read of 0x1234 after test 1, RD_LAT=1 → a_ack at cycle 4 with a_rdata=0xAB; b_rdata stays 0x00.
3. Simultaneous contention, FIXED_PRIO=0: A writes 0x5678←0xBC while B reads 0x1234, both req high continuously → A is served first (owner=1 after reset), then B; B receives b_rdata=0xAB; two non-overlapping ram_we/ack sequences.
4. Repeat test 3 with FIXED_PRIO=1 and both ports re-requesting after every ack → A is granted every time; B gets no ack until a_req drops.
5. Assert rst in WAIT during a B read of 0x5678 → ram_we=0, no b_ack, state=IDLE immediately; a fresh read afterwards returns 0xBC.
6. RD_LAT=3, A reads 0xFFFF after writing 0x5A there → a_ack at cycle 6; ram_addr held at 0xFFFF throughout WAIT; a_rdata=0x5A.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter and access sequencer in front of a 64K x 8
// synchronous-write RAM. Port A is the CPU load/store path and port B is the
// loader/DMA path. One access is in flight at a time. The RAM strobes are
// driven for one issue cycle. The sequencer then waits out the read latency
// and returns data to the winner with a one-cycle ack pulse.
//
// Handshake: a requester raises req with stable we/addr/wdata and holds req
// until its ack pulse. The command is latched on the grant edge, so later
// changes are ignored. A req still high in the cycle after ack is a new
// request. A req dropped before grant performs no access.
module ram_arbiter #(
    parameter int RD_LAT     = 1,    // cycles from issue edge to valid ram_rdata (1-4)
    parameter bit FIXED_PRIO = 1'b0  // 0: round-robin, 1: A wins every tie
) (
    input  logic        clk,
    input  logic        rst,
    // port A: CPU load/store
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    // port B: loader / DMA
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    // RAM side
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    // status
    output logic        busy,
    output logic        owner,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A read spends RD_LAT cycles in WAIT, counting down from RD_LAT-1 to 0.
    localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

    state_t     state;
    logic       cmd_we;     // latched direction of the granted command
    logic [1:0] wait_cnt;
    logic       grant_any;
    logic       grant_b;    // 1 when B wins this IDLE cycle

    assign dbg_state = state;

    // Pick the winner among the current requests; ties go to A under fixed
    // priority, otherwise to the port that did not win last time.
    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = 1'b0;
        if (a_req && b_req) begin
            grant_b = FIXED_PRIO ? 1'b0 : ~owner;
        end else begin
            grant_b = b_req;
        end
    end

    // Sequencer: grant, one-cycle issue, read-latency wait, one-cycle ack.
    // The RAM address/data registers double as the command latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            wait_cnt  <= 2'd0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 8'h00;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= 8'h00;
            b_rdata   <= 8'h00;
            busy      <= 1'b0;
            owner     <= 1'b1;  // so A wins the first round-robin tie
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner     <= grant_b;
                        cmd_we    <= grant_b ? b_we : a_we;
                        ram_we    <= grant_b ? b_we : a_we;
                        ram_addr  <= grant_b ? b_addr : a_addr;
                        ram_wdata <= grant_b ? b_wdata : a_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The strobe is live for this cycle only.
                    ram_we <= 1'b0;
                    if (cmd_we) begin
                        if (owner) begin
                            b_ack <= 1'b1;
                        end else begin
                            a_ack <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        // Only the owner's read register is ever updated.
                        if (owner) begin
                            b_rdata <= ram_rdata;
                            b_ack   <= 1'b1;
                        end else begin
                            a_rdata <= ram_rdata;
                            a_ack   <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter. Three instances cover the
// parameter corners: [0] RD_LAT=1 round-robin, [1] RD_LAT=1 fixed priority,
// and [2] RD_LAT=3 round-robin. Each instance has its own behavioural RAM.
// Every RAM is preset to a known address pattern.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;

    logic        a_req     [3];
    logic        a_we      [3];
    logic [15:0] a_addr    [3];
    logic [7:0]  a_wdata   [3];
    logic        a_ack     [3];
    logic [7:0]  a_rdata   [3];
    logic        b_req     [3];
    logic        b_we      [3];
    logic [15:0] b_addr    [3];
    logic [7:0]  b_wdata   [3];
    logic        b_ack     [3];
    logic [7:0]  b_rdata   [3];
    logic        ram_we    [3];
    logic [15:0] ram_addr  [3];
    logic [7:0]  ram_wdata [3];
    logic [7:0]  ram_rdata [3];
    logic        busy      [3];
    logic        owner     [3];
    logic [1:0]  dbg_state [3];

    // event counters from the negedge monitor
    int          we_cnt    [3];
    int          busy_cnt  [3];
    int          a_ack_cnt [3];
    int          b_ack_cnt [3];
    logic [15:0] wr_addr_last [3];
    logic [7:0]  wr_data_last [3];

    int compared   = 0;
    int mismatched = 0;
    int n;
    int s_we, s_busy, s_aack, s_back;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT instances, each with its own RAM model
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int LAT = (g == 2) ? 3 : 1;
        localparam bit FP  = (g == 1);

        ram_arbiter #(.RD_LAT(LAT), .FIXED_PRIO(FP)) dut (
            .clk       (clk),
            .rst       (rst),
            .a_req     (a_req[g]),
            .a_we      (a_we[g]),
            .a_addr    (a_addr[g]),
            .a_wdata   (a_wdata[g]),
            .a_ack     (a_ack[g]),
            .a_rdata   (a_rdata[g]),
            .b_req     (b_req[g]),
            .b_we      (b_we[g]),
            .b_addr    (b_addr[g]),
            .b_wdata   (b_wdata[g]),
            .b_ack     (b_ack[g]),
            .b_rdata   (b_rdata[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .busy      (busy[g]),
            .owner     (owner[g]),
            .dbg_state (dbg_state[g])
        );

        logic [7:0] mem [0:65535];
        logic [7:0] p1, p2, p3;

        assign ram_rdata[g] = (LAT == 1) ? p1 : p3;

        // RAM model: synchronous write, read data through an LAT-deep pipe.
        // Memory is preset to addr_lo + addr_hi + 0x11.
        initial begin
            for (int i = 0; i < 65536; i++) begin
                mem[i] = 8'(i[7:0] + i[15:8] + 8'h11);
            end
            p1 = 8'h00;
            p2 = 8'h00;
            p3 = 8'h00;
            forever begin
                @(posedge clk);
                if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
                p1 <= mem[ram_addr[g]];
                p2 <= p1;
                p3 <= p2;
            end
        end
    end

    // monitor: count strobe, busy and ack cycles mid-cycle
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ram_we[k] === 1'b1) begin
                we_cnt[k]++;
                wr_addr_last[k] = ram_addr[k];
                wr_data_last[k] = ram_wdata[k];
            end
            if (busy[k] === 1'b1)  busy_cnt[k]++;
            if (a_ack[k] === 1'b1) a_ack_cnt[k]++;
            if (b_ack[k] === 1'b1) b_ack_cnt[k]++;
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int g, input logic req, input logic we,
                           input logic [15:0] addr, input logic [7:0] wdata);
        a_req[g]   = req;
        a_we[g]    = we;
        a_addr[g]  = addr;
        a_wdata[g] = wdata;
    endtask

    task automatic drive_b(input int g, input logic req, input logic we,
                           input logic [15:0] addr, input logic [7:0] wdata);
        b_req[g]   = req;
        b_we[g]    = we;
        b_addr[g]  = addr;
        b_wdata[g] = wdata;
    endtask

    // steps until the chosen ack is seen; n = steps taken, -1 if budget ran out
    task automatic wait_ack(input int g, input bit on_b, input int budget, output int steps);
        steps = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if ((on_b ? b_ack[g] : a_ack[g]) === 1'b1) begin
                steps = i;
                break;
            end
        end
    endtask

    task automatic snap(input int g);
        s_we   = we_cnt[g];
        s_busy = busy_cnt[g];
        s_aack = a_ack_cnt[g];
        s_back = b_ack_cnt[g];
    endtask

    // directed sequence
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_a(k, 1'b0, 1'b0, 16'h0000, 8'h00);
            drive_b(k, 1'b0, 1'b0, 16'h0000, 8'h00);
        end
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("rst_state",     32'(dbg_state[0]), 32'd0);
        check("rst_ram_we",    32'(ram_we[0]),    32'd0);
        check("rst_ram_addr",  32'(ram_addr[0]),  32'h0);
        check("rst_ram_wdata", 32'(ram_wdata[0]), 32'h0);
        check("rst_a_ack",     32'(a_ack[0]),     32'd0);
        check("rst_b_ack",     32'(b_ack[0]),     32'd0);
        check("rst_a_rdata",   32'(a_rdata[0]),   32'h0);
        check("rst_b_rdata",   32'(b_rdata[0]),   32'h0);
        check("rst_busy",      32'(busy[0]),      32'd0);
        check("rst_owner",     32'(owner[0]),     32'd1);
        rst = 1'b0;
        step();

        // test 1: A write 0x1234 <- 0xAB
        snap(0);
        drive_a(0, 1'b1, 1'b1, 16'h1234, 8'hAB);
        wait_ack(0, 1'b0, 6, n);
        check("t1_ack_cycle", 32'(n + 1), 32'd3);
        check("t1_owner", 32'(owner[0]), 32'd0);
        drive_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t1_we_cycles", 32'(we_cnt[0] - s_we), 32'd1);
        check("t1_wr_addr", 32'(wr_addr_last[0]), 32'h1234);
        check("t1_wr_data", 32'(wr_data_last[0]), 32'hAB);
        check("t1_busy_cycles", 32'(busy_cnt[0] - s_busy), 32'd2);
        check("t1_ack_cycles", 32'(a_ack_cnt[0] - s_aack), 32'd1);
        check("t1_a_rdata", 32'(a_rdata[0]), 32'h0);
        check("t1_idle", 32'(dbg_state[0]), 32'd0);

        // test 2: A read 0x1234, RD_LAT=1
        snap(0);
        drive_a(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        wait_ack(0, 1'b0, 8, n);
        check("t2_ack_cycle", 32'(n + 1), 32'd4);
        check("t2_a_rdata", 32'(a_rdata[0]), 32'hAB);
        check("t2_b_rdata", 32'(b_rdata[0]), 32'h0);
        drive_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t2_no_we", 32'(we_cnt[0] - s_we), 32'd0);
        check("t2_busy_cycles", 32'(busy_cnt[0] - s_busy), 32'd3);
        check("t2_ack_low", 32'(a_ack[0]), 32'd0);

        // test 3: contention under round-robin; A first after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        snap(0);
        drive_a(0, 1'b1, 1'b1, 16'h5678, 8'hBC);
        drive_b(0, 1'b1, 1'b0, 16'h1234, 8'h00);
        wait_ack(0, 1'b0, 6, n);
        check("t3_a_ack_cycle", 32'(n + 1), 32'd3);
        check("t3_owner_a", 32'(owner[0]), 32'd0);
        check("t3_b_ack_during_a", 32'(b_ack[0]), 32'd0);
        drive_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_ack(0, 1'b1, 8, n);
        check("t3_b_ack_steps", 32'(n), 32'd4);
        check("t3_b_rdata", 32'(b_rdata[0]), 32'hAB);
        check("t3_owner_b", 32'(owner[0]), 32'd1);
        check("t3_a_rdata", 32'(a_rdata[0]), 32'h0);
        drive_b(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t3_we_cycles", 32'(we_cnt[0] - s_we), 32'd1);
        check("t3_wr_addr", 32'(wr_addr_last[0]), 32'h5678);
        check("t3_wr_data", 32'(wr_data_last[0]), 32'hBC);
        check("t3_a_acks", 32'(a_ack_cnt[0] - s_aack), 32'd1);
        check("t3_b_acks", 32'(b_ack_cnt[0] - s_back), 32'd1);

        // test 4: fixed priority, both requesting; A wins every time
        snap(1);
        drive_a(1, 1'b1, 1'b1, 16'h5678, 8'hBC);
        drive_b(1, 1'b1, 1'b0, 16'h1234, 8'h00);
        wait_ack(1, 1'b0, 6, n);
        check("t4_a_first", 32'(n), 32'd2);
        for (int r = 0; r < 3; r++) begin
            wait_ack(1, 1'b0, 6, n);
            check("t4_a_again", 32'(n), 32'd3);
        end
        check("t4_b_starved", 32'(b_ack_cnt[1] - s_back), 32'd0);
        check("t4_owner_a", 32'(owner[1]), 32'd0);
        drive_a(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_ack(1, 1'b1, 8, n);
        check("t4_b_ack_steps", 32'(n), 32'd4);
        check("t4_b_rdata", 32'(b_rdata[1]), 32'h57);
        drive_b(1, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t4_we_cycles", 32'(we_cnt[1] - s_we), 32'd4);
        check("t4_a_acks", 32'(a_ack_cnt[1] - s_aack), 32'd4);
        check("t4_b_acks", 32'(b_ack_cnt[1] - s_back), 32'd1);

        // test 5: reset in WAIT of a B read, and in ISSUE of an A write
        snap(0);
        drive_b(0, 1'b1, 1'b0, 16'h5678, 8'h00);
        step();
        check("t5_issue", 32'(dbg_state[0]), 32'd1);
        step();
        check("t5_wait", 32'(dbg_state[0]), 32'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_state", 32'(dbg_state[0]), 32'd0);
        check("t5_rst_we", 32'(ram_we[0]), 32'd0);
        check("t5_rst_busy", 32'(busy[0]), 32'd0);
        drive_b(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        rst = 1'b0;
        step();
        step();
        check("t5_no_b_ack", 32'(b_ack_cnt[0] - s_back), 32'd0);
        check("t5_b_rdata", 32'(b_rdata[0]), 32'h0);
        drive_a(0, 1'b1, 1'b1, 16'h0042, 8'h99);
        step();
        check("t5_we_issue", 32'(ram_we[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_we_drop", 32'(ram_we[0]), 32'd0);
        drive_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        rst = 1'b0;
        step();
        drive_b(0, 1'b1, 1'b0, 16'h5678, 8'h00);
        wait_ack(0, 1'b1, 8, n);
        check("t5_fresh_ack_cycle", 32'(n + 1), 32'd4);
        check("t5_fresh_b_rdata", 32'(b_rdata[0]), 32'hBC);
        drive_b(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        drive_a(0, 1'b1, 1'b0, 16'h0042, 8'h00);
        wait_ack(0, 1'b0, 8, n);
        check("t5_aborted_write", 32'(a_rdata[0]), 32'h53);
        drive_a(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();

        // test 6: RD_LAT=3, write then read 0xFFFF
        snap(2);
        drive_a(2, 1'b1, 1'b1, 16'hFFFF, 8'h5A);
        wait_ack(2, 1'b0, 6, n);
        check("t6_wr_ack_cycle", 32'(n + 1), 32'd3);
        drive_a(2, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t6_wr_addr", 32'(wr_addr_last[2]), 32'hFFFF);
        check("t6_wr_data", 32'(wr_data_last[2]), 32'h5A);
        drive_a(2, 1'b1, 1'b0, 16'hFFFF, 8'h00);
        step();
        check("t6_issue_state", 32'(dbg_state[2]), 32'd1);
        check("t6_issue_addr", 32'(ram_addr[2]), 32'hFFFF);
        check("t6_issue_we", 32'(ram_we[2]), 32'd0);
        for (int w = 0; w < 3; w++) begin
            step();
            check("t6_wait_state", 32'(dbg_state[2]), 32'd2);
            check("t6_wait_addr", 32'(ram_addr[2]), 32'hFFFF);
            check("t6_wait_ack", 32'(a_ack[2]), 32'd0);
        end
        step();
        check("t6_ack", 32'(a_ack[2]), 32'd1);
        check("t6_a_rdata", 32'(a_rdata[2]), 32'h5A);
        drive_a(2, 1'b0, 1'b0, 16'h0000, 8'h00);
        step();
        check("t6_busy_low", 32'(busy[2]), 32'd0);
        check("t6_we_cycles", 32'(we_cnt[2] - s_we), 32'd1);
        check("t6_b_rdata", 32'(b_rdata[2]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
